// File: rtl/frac_lutk_cfgload.sv
// frac_lutk_cfgload: fracturable K-input LUT with an on-block configuration
// store loaded through a word-wide valid/ready port.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset, clears all state
//   in          LUT inputs, in[0] is the address LSB
//   cfg_start   pulse that begins a load (taken only when idle)
//   cfg_abort   discards an in-progress load
//   cfg_valid   cfg_data holds a valid beat
//   cfg_data    configuration word, beat b bit w -> vector bit b*CFG_W+w
//   cfg_ready   block accepts a beat (registered, high only while loading)
//   cfg_done    one-cycle pulse in the cycle after a commit
//   configured  high once any load has committed
//   lutk2_out   four (K-2)-input LUT outputs
//   lutk1_out   two (K-1)-input LUT outputs
//   lutk_out    full K-input LUT output
//
// Config vector: [2^K-1:0] truth table, [2^K] mode0, [2^K+1] mode1,
// [2^K+2] reg_en.

module frac_lutk_cfgload #(
  parameter int unsigned K     = 6,
  parameter int unsigned CFG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [K-1:0]     in,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             configured,
  output logic [3:0]       lutk2_out,
  output logic [1:0]       lutk1_out,
  output logic             lutk_out
);

  localparam int unsigned TW    = 2 ** K;
  localparam int unsigned N     = TW + 3;
  localparam int unsigned BEATS = (N + CFG_W - 1) / CFG_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     stage;
  logic [N-1:0]     stage_wr;
  logic [N-1:0]     active;
  logic [6:0]       out_q;

  logic [TW-1:0]    tt;
  logic             mode0;
  logic             mode1;
  logic             reg_en;
  logic [K-1:0]     addr;
  logic             k_c;
  logic [1:0]       k1_c;
  logic [3:0]       k2_c;

  // Staging image with the current beat merged into slot cnt; it is both the
  // next staging value and, on the final beat, the value committed to active.
  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    localparam int unsigned B = gi / CFG_W;
    localparam int unsigned W = gi % CFG_W;
    assign stage_wr[gi] = (cnt == CNT_W'(B)) ? cfg_data[W] : stage[gi];
  end

  assign tt     = active[TW-1:0];
  assign mode0  = active[TW];
  assign mode1  = active[TW+1];
  assign reg_en = active[TW+2];

  // Mode bits force the top two address bits high to select upper sub-tables.
  assign addr = {in[K-1] | mode1, in[K-2] | mode0, in[K-3:0]};
  assign k_c  = tt[addr];

  for (genvar gj = 0; gj < 2; gj++) begin : g_k1
    assign k1_c[gj] = tt[{1'(gj), addr[K-2:0]}];
  end

  for (genvar gj = 0; gj < 4; gj++) begin : g_k2
    assign k2_c[gj] = tt[{2'(gj), addr[K-3:0]}];
  end

  // Output register captures every edge; reg_en only selects which path drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= {k2_c, k1_c, k_c};
    end
  end

  assign lutk_out  = reg_en ? out_q[0]   : k_c;
  assign lutk1_out = reg_en ? out_q[2:1] : k1_c;
  assign lutk2_out = reg_en ? out_q[6:3] : k2_c;

  // Load FSM: staged beats, atomic commit on the final accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      stage      <= '0;
      active     <= '0;
      configured <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cfg_done <= 1'b0;
          if (cfg_start) begin
            state     <= LOAD;
            cnt       <= '0;
            cfg_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_abort) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
          end else if (cfg_valid) begin
            stage <= stage_wr;
            if (cnt == CNT_W'(BEATS - 1)) begin
              active     <= stage_wr;
              configured <= 1'b1;
              cfg_done   <= 1'b1;
              cfg_ready  <= 1'b0;
              state      <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          cfg_done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cfg_done  <= 1'b0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
